// File: rtl/game_pkg.sv
// Shared game constants: coordinate width, march state encoding and default
// playfield geometry, used by the march controller and the renderer.
package game_pkg;
    localparam int COORD_W = 11;
    localparam int FCNT_W  = 8;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [FCNT_W-1:0]  fcnt_t;

    typedef enum logic [1:0] {
        MOVE_R = 2'd0,
        MOVE_L = 2'd1,
        LANDED = 2'd2
    } march_state_t;

    localparam coord_t DEF_X_LEFT  = 11'd16;
    localparam coord_t DEF_X_RIGHT = 11'd400;
    localparam coord_t DEF_Y_START = 11'd32;
    localparam coord_t DEF_Y_LIMIT = 11'd400;
endpackage

// File: rtl/tick_edge.sv
// Rising-edge detector: one-cycle registered pulse per 0->1 of a level input.
module tick_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);
    logic hist;

    // History resets high so a level already asserted at reset release is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist  <= 1'b1;
            pulse <= 1'b0;
        end else begin
            hist  <= level;
            pulse <= level & ~hist;
        end
    end
endmodule

// File: rtl/enemy_march_ctrl.sv
// Enemy formation march: steps the formation sideways once every
// frames_per_step frames, descends at each edge, and lands at Y_LIMIT.
module enemy_march_ctrl
    import game_pkg::*;
#(
    parameter coord_t X_LEFT      = DEF_X_LEFT,
    parameter coord_t X_RIGHT     = DEF_X_RIGHT,
    parameter int     STEP_X      = 4,
    parameter int     STEP_Y      = 16,
    parameter coord_t Y_START     = DEF_Y_START,
    parameter coord_t Y_LIMIT     = DEF_Y_LIMIT,
    parameter int     FRAMES_INIT = 8,
    parameter int     FRAMES_MIN  = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         frame_tick,
    input  logic         speed_up,
    input  logic         pause,
    output logic [10:0]  pos_x,
    output logic [10:0]  pos_y,
    output logic         dir,
    output logic         step_pulse,
    output logic         landed
);
    localparam logic [11:0] STEP_X12 = 12'(STEP_X);
    localparam logic [11:0] STEP_Y12 = 12'(STEP_Y);
    localparam coord_t      STEP_X11 = coord_t'(STEP_X);
    localparam fcnt_t       FPS_INIT = fcnt_t'(FRAMES_INIT);
    localparam fcnt_t       FPS_MIN  = fcnt_t'(FRAMES_MIN);

    logic         frame_ev;
    march_state_t state, state_nx;
    fcnt_t        frame_cnt, cnt_nx, fps, fps_nx;
    coord_t       pos_x_nx, pos_y_nx;
    logic         dir_nx, step_nx, landed_nx, do_step;
    logic [8:0]   cnt_inc;
    logic [11:0]  x_inc, x_floor, y_inc;
    coord_t       x_dec;

    tick_edge u_tick_edge (
        .clk   (clk),
        .reset (reset),
        .level (frame_tick),
        .pulse (frame_ev)
    );

    // 12-bit arithmetic so sums and differences never wrap before clamping.
    assign cnt_inc = {1'b0, frame_cnt} + 9'd1;
    assign x_inc   = {1'b0, pos_x} + STEP_X12;
    assign x_floor = {1'b0, X_LEFT} + STEP_X12;
    assign x_dec   = pos_x - STEP_X11;
    assign y_inc   = {1'b0, pos_y} + STEP_Y12;

    always_comb begin
        state_nx  = state;
        cnt_nx    = frame_cnt;
        fps_nx    = fps;
        pos_x_nx  = pos_x;
        pos_y_nx  = pos_y;
        landed_nx = landed;
        step_nx   = 1'b0;
        do_step   = 1'b0;

        if (speed_up && fps > FPS_MIN)
            fps_nx = fps - fcnt_t'(1);

        if (frame_ev && !pause && state != LANDED) begin
            if (cnt_inc >= {1'b0, fps}) begin
                cnt_nx  = '0;
                do_step = 1'b1;
            end else begin
                cnt_nx = cnt_inc[FCNT_W-1:0];
            end
        end

        if (do_step) begin
            step_nx = 1'b1;
            case (state)
                MOVE_R: begin
                    if (pos_x < X_RIGHT)
                        pos_x_nx = (x_inc > {1'b0, X_RIGHT}) ? X_RIGHT : x_inc[10:0];
                    else if (y_inc >= {1'b0, Y_LIMIT}) begin
                        pos_y_nx  = Y_LIMIT;
                        state_nx  = LANDED;
                        landed_nx = 1'b1;
                    end else begin
                        pos_y_nx = y_inc[10:0];
                        state_nx = MOVE_L;
                    end
                end
                MOVE_L: begin
                    if (pos_x > X_LEFT)
                        pos_x_nx = ({1'b0, pos_x} <= x_floor) ? X_LEFT : x_dec;
                    else if (y_inc >= {1'b0, Y_LIMIT}) begin
                        pos_y_nx  = Y_LIMIT;
                        state_nx  = LANDED;
                        landed_nx = 1'b1;
                    end else begin
                        pos_y_nx = y_inc[10:0];
                        state_nx = MOVE_R;
                    end
                end
                default: step_nx = 1'b0;
            endcase
        end

        // Direction tracks the move state; LANDED freezes the last heading.
        case (state_nx)
            MOVE_R:  dir_nx = 1'b0;
            MOVE_L:  dir_nx = 1'b1;
            default: dir_nx = dir;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= MOVE_R;
            frame_cnt  <= '0;
            fps        <= FPS_INIT;
            pos_x      <= X_LEFT;
            pos_y      <= Y_START;
            dir        <= 1'b0;
            step_pulse <= 1'b0;
            landed     <= 1'b0;
        end else begin
            state      <= state_nx;
            frame_cnt  <= cnt_nx;
            fps        <= fps_nx;
            pos_x      <= pos_x_nx;
            pos_y      <= pos_y_nx;
            dir        <= dir_nx;
            step_pulse <= step_nx;
            landed     <= landed_nx;
        end
    end
endmodule

// File: tb/tb_enemy_march_ctrl.sv
// Directed bench for enemy_march_ctrl: default instance plus two
// re-parameterised instances placed near the right edge and near the floor.
module tb_enemy_march_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_tick = 1'b1;
    logic        speed_up = 1'b0;
    logic        pause = 1'b0;
    logic [10:0] ax, ay, bx, by, cx, cy;
    logic        adir, astep, aland, bdir, bstep, bland, cdir, cstep, cland;

    int checks = 0;
    int fails  = 0;
    int a_steps = 0;
    int c_steps = 0;

    always #5 clk = ~clk;

    enemy_march_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .speed_up(speed_up),
        .pause(pause), .pos_x(ax), .pos_y(ay), .dir(adir), .step_pulse(astep),
        .landed(aland)
    );

    enemy_march_ctrl #(.X_LEFT(11'd396)) dut_b (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .speed_up(speed_up),
        .pause(pause), .pos_x(bx), .pos_y(by), .dir(bdir), .step_pulse(bstep),
        .landed(bland)
    );

    enemy_march_ctrl #(.X_LEFT(11'd16), .X_RIGHT(11'd16), .Y_START(11'd376),
                       .FRAMES_INIT(1)) dut_c (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .speed_up(speed_up),
        .pause(pause), .pos_x(cx), .pos_y(cy), .dir(cdir), .step_pulse(cstep),
        .landed(cland)
    );

    always @(negedge clk) begin
        if (astep) a_steps++;
        if (cstep) c_steps++;
    end

    typedef struct {
        int          nfr;
        logic        pse;
        logic [10:0] ex;
        logic [10:0] ey;
        logic        edir;
        int          esteps;
        int          ecnt;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int base;
        vecs[0] = '{7,  1'b0, 11'd16, 11'd32, 1'b0, 0, 7};
        vecs[1] = '{1,  1'b0, 11'd20, 11'd32, 1'b0, 1, 0};
        vecs[2] = '{3,  1'b0, 11'd20, 11'd32, 1'b0, 1, 3};
        vecs[3] = '{20, 1'b1, 11'd20, 11'd32, 1'b0, 1, 3};
        vecs[4] = '{5,  1'b0, 11'd24, 11'd32, 1'b0, 2, 0};
        vecs[5] = '{16, 1'b0, 11'd32, 11'd32, 1'b0, 4, 0};

        // Reset values, with frame_tick already high at release.
        repeat (2) @(negedge clk);
        chk("rst_x", ax, 16);
        chk("rst_y", ay, 32);
        chk("rst_dir", adir, 0);
        chk("rst_step", astep, 0);
        chk("rst_landed", aland, 0);
        chk("rst_fps", dut.fps, 8);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("tick_at_release_cnt", dut.frame_cnt, 0);

        base = a_steps;
        for (int i = 0; i < 6; i++) begin
            pause = vecs[i].pse;
            frames(vecs[i].nfr);
            pause = 1'b0;
            chk($sformatf("vec%0d_x", i), ax, vecs[i].ex);
            chk($sformatf("vec%0d_y", i), ay, vecs[i].ey);
            chk($sformatf("vec%0d_dir", i), adir, vecs[i].edir);
            chk($sformatf("vec%0d_steps", i), a_steps - base, vecs[i].esteps);
            chk($sformatf("vec%0d_cnt", i), dut.frame_cnt, vecs[i].ecnt);
        end

        // Level held high for 800 cycles counts once.
        do_reset();
        base = a_steps;
        frame_tick = 1'b1;
        repeat (800) @(negedge clk);
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_cnt", dut.frame_cnt, 1);
        chk("held_x", ax, 16);
        frames(7);
        chk("held_x_after", ax, 20);
        chk("held_steps", a_steps - base, 1);

        // Ten speed_up pulses saturate at one frame per step.
        do_reset();
        base = a_steps;
        for (int i = 0; i < 10; i++) begin
            speed_up = 1'b1;
            @(negedge clk);
            speed_up = 1'b0;
        end
        chk("fast_fps", dut.fps, 1);
        frames(5);
        chk("fast_x", ax, 36);
        chk("fast_steps", a_steps - base, 5);

        // speed_up coinciding with a step: step keeps old period.
        do_reset();
        frames(7);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        speed_up = 1'b1;
        @(negedge clk);
        speed_up = 1'b0;
        repeat (2) @(negedge clk);
        chk("coinc_x", ax, 20);
        chk("coinc_fps", dut.fps, 7);
        frames(6);
        chk("coinc_x6", ax, 20);
        frames(1);
        chk("coinc_x7", ax, 24);

        // Right-edge clamp and descent.
        do_reset();
        chk("b_start_x", bx, 396);
        frames(8);
        chk("b_edge_x", bx, 400);
        chk("b_edge_y", by, 32);
        frames(8);
        chk("b_desc_x", bx, 400);
        chk("b_desc_y", by, 48);
        chk("b_desc_dir", bdir, 1);

        // Landing from MOVE_L at X_LEFT.
        do_reset();
        base = c_steps;
        frames(1);
        chk("c_pre_y", cy, 392);
        chk("c_pre_dir", cdir, 1);
        chk("c_pre_landed", cland, 0);
        frames(1);
        chk("c_land_y", cy, 400);
        chk("c_land_flag", cland, 1);
        chk("c_land_dir", cdir, 1);
        frames(3);
        chk("c_frozen_y", cy, 400);
        chk("c_frozen_x", cx, 16);
        chk("c_frozen_steps", c_steps - base, 2);

        // Asynchronous reset while landed.
        #2 reset = 1'b0;
        #1;
        chk("async_c_landed", cland, 0);
        chk("async_c_y", cy, 376);
        chk("async_c_dir", cdir, 0);
        chk("async_a_x", ax, 16);
        chk("async_a_cnt", dut.frame_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/enemy_march_ctrl.md
ENEMY_MARCH_CTRL -- requirements
Module: enemy_march_ctrl

Interface
REQ-001 The block SHALL have parameter X_LEFT, default 11'd16, the leftmost formation x.
REQ-002 The block SHALL have parameter X_RIGHT, default 11'd400, the rightmost formation x.
REQ-003 The block SHALL have parameter STEP_X, default 4, the horizontal pixels per step.
REQ-004 The block SHALL have parameter STEP_Y, default 16, the vertical pixels per descent.
REQ-005 The block SHALL have parameters Y_START, default 11'd32, and Y_LIMIT, default 11'd400, the initial and landing y.
REQ-006 The block SHALL have parameters FRAMES_INIT, default 8, and FRAMES_MIN, default 1, the initial and minimum frames per step.
REQ-007 The block SHALL have port clk, input, 1 bit, the single system clock.
REQ-008 The block SHALL have port reset, input, 1 bit, an asynchronous active-low reset.
REQ-009 The block SHALL have port frame_tick, input, 1 bit, a level that is high for one scan line per frame; its rising edge marks one frame.
REQ-010 The block SHALL have port speed_up, input, 1 bit, a single-cycle request to shorten the step period.
REQ-011 The block SHALL have port pause, input, 1 bit, which freezes motion while high.
REQ-012 The block SHALL have port pos_x, output, 11 bits, the formation x fed to the renderer.
REQ-013 The block SHALL have port pos_y, output, 11 bits, the formation y fed to the renderer.
REQ-014 The block SHALL have port dir, output, 1 bit: 0 = moving right, 1 = moving left.
REQ-015 The block SHALL have port step_pulse, output, 1 bit, high for exactly one cycle on each horizontal or descent step.
REQ-016 The block SHALL have port landed, output, 1 bit, a sticky flag meaning the formation has reached Y_LIMIT.

Function
REQ-017 A frame event SHALL be asserted one cycle after a 0->1 transition of frame_tick, with one event per transition regardless of how long the level stays high.
REQ-018 Frame events SHALL be ignored while pause=1 or landed=1; frame_cnt SHALL hold its value during these times.
REQ-019 frame_cnt SHALL increment on each accepted frame event; when frame_cnt+1 >= frames_per_step, a step SHALL occur and frame_cnt SHALL return to 0.
REQ-020 The FSM SHALL have states MOVE_R, MOVE_L and LANDED.
REQ-021 On a step in MOVE_R with pos_x < X_RIGHT: pos_x SHALL become min(pos_x+STEP_X, X_RIGHT), and pos_y SHALL be unchanged.
REQ-022 On a step in MOVE_R with pos_x == X_RIGHT: a descent SHALL occur, with pos_y += STEP_Y, pos_x unchanged, and the next state MOVE_L.
REQ-023 MOVE_L SHALL mirror MOVE_R: pos_x becomes max(pos_x-STEP_X, X_LEFT); at X_LEFT, a descent occurs and the next state is MOVE_R.
REQ-024 A descent whose result is >= Y_LIMIT SHALL set pos_y=Y_LIMIT, enter LANDED and set landed=1; LANDED SHALL be exited only by reset.
REQ-025 dir SHALL equal 1 exactly when the state is MOVE_L; in LANDED, dir SHALL keep its last value.
REQ-026 step_pulse SHALL assert in the same cycle that pos_x or pos_y updates.
REQ-027 speed_up SHALL decrement frames_per_step by 1, saturating at FRAMES_MIN; a speed_up that coincides with a step SHALL take effect from the next frame, and that step SHALL use the old period.
REQ-028 All x arithmetic SHALL be done at 12 bits before clamping, so there is no wrap at 0 or 2047.
REQ-029 Outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-030 While reset=0, the block SHALL hold pos_x=X_LEFT, pos_y=Y_START, dir=0, step_pulse=0, landed=0, state MOVE_R, frame_cnt=0 and frames_per_step=FRAMES_INIT.
REQ-031 The frame_tick history register SHALL reset to 1, so that a tick already high at reset release is not counted.
REQ-032 Reset asserted mid-step or in LANDED SHALL restore the REQ-030 values immediately, asynchronously.

Structure
REQ-033 The state encoding, the 11-bit coordinate width and the default geometry constants SHALL live in shared package game_pkg, which the renderer also uses.
REQ-034 Rising-edge detection SHALL be a sub-module tick_edge (clk, reset, level in, one-cycle pulse out).

Verification
REQ-035 Bench: reset, then 8 frame_tick rising edges -> one step_pulse after the 8th edge, pos_x=20.
REQ-036 Bench: a frame_tick held high for 800 cycles -> exactly one counted frame.
REQ-037 Bench: pos_x=396 in MOVE_R, 16 frames -> pos_x=400, then a descent to pos_y=48 with dir=1.
REQ-038 Bench: 10 speed_up pulses from reset -> frames_per_step=1, so every frame steps.
REQ-039 Bench: pos_y=392 in MOVE_L at X_LEFT, then a step -> pos_y=400, landed=1, and further frames cause no change.
REQ-040 Bench: pause=1 across 20 frames -> pos_x and frame_cnt unchanged; reset during LANDED -> REQ-030 values.
